// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB initiator.
// Turns a valid/ready request into one APB SETUP/ACCESS transfer and returns
// exactly one response pulse per accepted request. A bounded wait-state
// counter aborts transfers whose slave never raises pready.
module apb_master_bridge #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    // A zero TIMEOUT still needs a legal (one-bit) counter even though it is never compared.
    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // The last permitted wait cycle has been reached; abort instead of waiting again.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    // Handshake and APB control strobes are pure decodes of the state register.
    assign req_ready = (state == ST_IDLE);
    assign psel      = (state != ST_IDLE);
    assign penable   = (state == ST_ACCESS);

    // State sequencing, request capture and wait-state counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            paddr    <= '0;
            pwrite   <= 1'b0;
            pwdata   <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        paddr    <= req_addr;
                        pwrite   <= req_write;
                        pwdata   <= req_wdata;
                        wait_cnt <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready || timeout_hit) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Response generation: a one-cycle pulse on completion or timeout, data held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == ST_ACCESS) begin
                if (pready) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= pslverr;
                    rsp_rdata <= pwrite ? '0 : prdata;
                end else if (timeout_hit) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed bench for apb_master_bridge (TIMEOUT = 8).
// A driver issues requests and queues hand-computed responses; a monitor pops
// and compares whenever rsp_valid is seen, and watches the APB bus each cycle.
module tb_apb_master_bridge;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    apb_master_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .psel     (psel),
        .penable  (penable),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    // Slave model configuration for the transfer in flight.
    int          sl_waits = 0;
    logic        sl_err   = 1'b0;
    logic [31:0] sl_rdata = '0;
    logic        sl_hang  = 1'b0;
    int          acc_cnt  = 0;

    // What the bus must show while psel is high.
    logic [ADDR_W-1:0] exp_addr  = '0;
    logic              exp_write = 1'b0;
    logic [DATA_W-1:0] exp_wdata = '0;

    int   pen_run      = 0;
    int   last_pen_run = 0;
    logic prev_psel    = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, need 0x%08h", name, act, req);
        end
    endtask

    // Slave: answers after sl_waits low ACCESS cycles, drives noise whenever its outputs must be ignored.
    always @(negedge clk) begin
        if (psel && penable) begin
            if (!sl_hang && acc_cnt == sl_waits) begin
                pready  = 1'b1;
                prdata  = sl_rdata;
                pslverr = sl_err;
            end else begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            pslverr = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: response scoreboard plus bus stability checks.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, need no response", cyc);
            end else begin
                cur = exp_q.pop_front();
                checkOutput({cur.name, " rdata"}, rsp_rdata, cur.rdata);
                checkOutput({cur.name, " err"}, {31'b0, rsp_err}, {31'b0, cur.err});
                checkOutput({cur.name, " cycle"}, 32'(cyc), 32'(cur.due));
            end
        end
        if (psel) begin
            checkOutput("paddr", {12'b0, paddr}, {12'b0, exp_addr});
            checkOutput("pwrite", {31'b0, pwrite}, {31'b0, exp_write});
            checkOutput("pwdata", pwdata, exp_wdata);
            if (!penable) checkOutput("setup_after_idle", {31'b0, prev_psel}, 32'd0);
        end
        if (penable && !psel) checkOutput("penable_without_psel", {31'b0, psel}, 32'd1);
        if (penable) begin
            pen_run++;
        end else if (pen_run > 0) begin
            last_pen_run = pen_run;
            pen_run      = 0;
        end
        prev_psel = psel;
    end

    task automatic applyStimulus(input string name, input logic wr, input logic [19:0] addr,
                                 input logic [31:0] wdata, input int waits, input logic err,
                                 input logic [31:0] rdata, input logic hang, input logic exp_rsp,
                                 input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s accept: got req_ready=0 for 60 cycles, need 1", name);
            req_valid = 1'b0;
            return;
        end
        sl_waits  = waits;
        sl_err    = err;
        sl_rdata  = rdata;
        sl_hang   = hang;
        exp_addr  = addr;
        exp_write = wr;
        exp_wdata = wdata;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        if (exp_rsp) exp_q.push_back('{rdata: exp_rdata, err: exp_err, due: cyc + lat, name: name});
        @(posedge clk);
        #1;
    endtask

    task automatic dropReq();
        req_valid = 1'b0;
    endtask

    task automatic waitDone();
        int guard = 0;
        while ((exp_q.size() != 0 || psel) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || psel) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL wait_done: got %0d pending responses, need 0", exp_q.size());
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, need $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 20'h12345;
        req_wdata = 32'h55AA55AA;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        // Reset held for two cycles with a request pending.
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst req_ready", {31'b0, req_ready}, 32'd1);
            checkOutput("rst psel", {31'b0, psel}, 32'd0);
            checkOutput("rst penable", {31'b0, penable}, 32'd0);
            checkOutput("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end
        checkOutput("rst paddr", {12'b0, paddr}, 32'd0);
        checkOutput("rst pwdata", pwdata, 32'd0);
        checkOutput("rst pwrite", {31'b0, pwrite}, 32'd0);
        checkOutput("rst rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst rsp_err", {31'b0, rsp_err}, 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst psel", {31'b0, psel}, 32'd0);

        applyStimulus("wr_zero_wait", 1'b1, 20'h02004, 32'hDEADBEEF, 0, 1'b0, 32'hFFFF0000, 1'b0,
                      1'b1, 32'h0, 1'b0, 3);
        dropReq();
        waitDone();
        checkOutput("wr_zero_wait penable_cycles", 32'(last_pen_run), 32'd1);

        applyStimulus("rd_wait4", 1'b0, 20'h0A008, 32'h0, 4, 1'b0, 32'h12345678, 1'b0,
                      1'b1, 32'h12345678, 1'b0, 7);
        dropReq();
        waitDone();
        checkOutput("rd_wait4 penable_cycles", 32'(last_pen_run), 32'd5);

        applyStimulus("rd_slverr", 1'b0, 20'h00100, 32'h0, 0, 1'b1, 32'hCAFE0000, 1'b0,
                      1'b1, 32'hCAFE0000, 1'b1, 3);
        dropReq();
        waitDone();

        applyStimulus("rd_timeout", 1'b0, 20'h0F000, 32'h0, 0, 1'b0, 32'h77777777, 1'b1,
                      1'b1, 32'h0, 1'b1, 10);
        dropReq();
        waitDone();
        checkOutput("rd_timeout penable_cycles", 32'(last_pen_run), 32'd8);

        applyStimulus("wr_after_timeout", 1'b1, 20'h00010, 32'h00001234, 1, 1'b0, 32'h0, 1'b0,
                      1'b1, 32'h0, 1'b0, 4);
        dropReq();
        waitDone();

        applyStimulus("wr_slverr", 1'b1, 20'h00020, 32'hA5A5A5A5, 2, 1'b1, 32'h0, 1'b0,
                      1'b1, 32'h0, 1'b1, 5);
        dropReq();
        waitDone();

        applyStimulus("rd_unmapped", 1'b0, 20'hFFFF0, 32'h0, 0, 1'b0, 32'h0, 1'b0,
                      1'b1, 32'h0, 1'b0, 3);
        dropReq();
        waitDone();

        // Three requests with req_valid never dropping in between.
        applyStimulus("b2b_0", 1'b0, 20'h00004, 32'h0, 0, 1'b0, 32'h000000A1, 1'b0,
                      1'b1, 32'h000000A1, 1'b0, 3);
        applyStimulus("b2b_1", 1'b0, 20'h00008, 32'h0, 0, 1'b0, 32'h000000A2, 1'b0,
                      1'b1, 32'h000000A2, 1'b0, 3);
        applyStimulus("b2b_2", 1'b1, 20'h0000C, 32'h000000B3, 0, 1'b0, 32'h0, 1'b0,
                      1'b1, 32'h0, 1'b0, 3);
        dropReq();
        waitDone();

        // Reset during ACCESS: the aborted request must never answer.
        applyStimulus("rst_mid", 1'b0, 20'h0C0C0, 32'h0, 0, 1'b0, 32'h0, 1'b1,
                      1'b0, 32'h0, 1'b0, 0);
        dropReq();
        begin
            int guard = 0;
            while (!penable && guard < 10) begin
                @(negedge clk);
                guard++;
            end
        end
        checkOutput("rst_mid in_access", {31'b0, penable}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid psel", {31'b0, psel}, 32'd0);
        checkOutput("rst_mid penable", {31'b0, penable}, 32'd0);
        checkOutput("rst_mid rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst     = 1'b0;
        sl_hang = 1'b0;
        repeat (12) @(negedge clk);

        applyStimulus("rd_after_rst", 1'b0, 20'h00300, 32'h0, 0, 1'b0, 32'h0BADF00D, 1'b0,
                      1'b1, 32'h0BADF00D, 1'b0, 3);
        dropReq();
        waitDone();

        repeat (4) @(negedge clk);
        checkOutput("pending_at_end", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
